// File: rtl/ahb_tdes_pkg.sv
// Shared encodings for the AHB-Lite front end of the Triple-DES core:
// transfer types, register offsets and the bus response code.
package ahb_tdes_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [7:0] OFF_DATA   = 8'h00;
    localparam logic [7:0] OFF_KEY1   = 8'h08;
    localparam logic [7:0] OFF_KEY2   = 8'h10;
    localparam logic [7:0] OFF_KEY3   = 8'h18;
    localparam logic [7:0] OFF_CTRL   = 8'h20;
    localparam logic [7:0] OFF_RESULT = 8'h28;
    localparam logic [7:0] OFF_STATUS = 8'h30;

    localparam logic HRESP_OKAY = 1'b0;

endpackage

// File: rtl/ahb_lite_slave_controller.sv
// Zero-wait-state AHB-Lite register slave feeding the Triple-DES core:
// one address-phase pipeline stage plus the data/key/control/result registers.
module ahb_lite_slave_controller
    import ahb_tdes_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HBURST,
    input  logic [2:0]  HSIZE,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HADDR,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HRESP,
    input  logic        outputEnable,
    input  logic [63:0] outputData,
    output logic        enable,
    output logic        encryptionType,
    output logic [63:0] data,
    output logic [63:0] key1,
    output logic [63:0] key2,
    output logic [63:0] key3
);

    logic [7:0]  off_reg;
    logic        wr_reg;
    logic        valid_reg;
    logic        hit_reg;
    logic [63:0] data_reg;
    logic [63:0] key_reg [3];
    logic        enc_reg;
    logic        enable_reg;
    logic [63:0] result_reg;
    logic        status_reg;
    logic [63:0] rdata_next;

    logic accept;
    logic dphase;
    logic wr_data;
    logic wr_ctrl;

    // Only NONSEQ/SEQ have bit 1 set, so HTRANS[1] alone qualifies a real transfer.
    assign accept  = HSEL & HREADY & HTRANS[1];
    assign dphase  = valid_reg & hit_reg;
    assign wr_data = dphase & wr_reg & (off_reg == OFF_DATA);
    assign wr_ctrl = dphase & wr_reg & (off_reg == OFF_CTRL);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            off_reg    <= '0;
            wr_reg     <= 1'b0;
            valid_reg  <= 1'b0;
            hit_reg    <= 1'b0;
            data_reg   <= '0;
            enc_reg    <= 1'b0;
            enable_reg <= 1'b0;
            result_reg <= '0;
            status_reg <= 1'b0;
        end else begin
            valid_reg <= accept;
            if (accept) begin
                off_reg <= HADDR[7:0];
                wr_reg  <= HWRITE;
                hit_reg <= (HADDR[31:8] == BASE_ADDR[31:8]);
            end
            if (wr_data)
                data_reg <= HWDATA;
            if (wr_ctrl)
                enc_reg <= HWDATA[0];
            enable_reg <= wr_ctrl;
            if (outputEnable)
                result_reg <= outputData;
            // A new start request invalidates any result still sitting in RESULT.
            if (wr_ctrl)
                status_reg <= 1'b0;
            else if (outputEnable)
                status_reg <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            localparam logic [7:0] KEY_OFF = OFF_KEY1 + 8'(gi * 8);
            always_ff @(posedge HCLK) begin
                if (HRESET)
                    key_reg[gi] <= '0;
                else if (dphase && wr_reg && off_reg == KEY_OFF)
                    key_reg[gi] <= HWDATA;
            end
        end
    endgenerate

    always_comb begin
        rdata_next = '0;
        if (dphase && !wr_reg) begin
            case (off_reg)
                OFF_DATA:   rdata_next = data_reg;
                OFF_KEY1:   rdata_next = key_reg[0];
                OFF_KEY2:   rdata_next = key_reg[1];
                OFF_KEY3:   rdata_next = key_reg[2];
                OFF_CTRL:   rdata_next = {63'b0, enc_reg};
                OFF_RESULT: rdata_next = result_reg;
                OFF_STATUS: rdata_next = {63'b0, status_reg};
                default:    rdata_next = '0;
            endcase
        end
    end

    assign HRDATA         = rdata_next;
    assign HRESP          = HRESP_OKAY;
    assign enable         = enable_reg;
    assign encryptionType = enc_reg;
    assign data           = data_reg;
    assign key1           = key_reg[0];
    assign key2           = key_reg[1];
    assign key3           = key_reg[2];

    logic unused_inputs;
    assign unused_inputs = &{1'b0, HMASTLOCK, HBURST, HSIZE, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb_lite_slave_controller.sv
// Self-checking bench for the AHB-Lite Triple-DES register slave: a vector table
// driven through a pipelined bus stepper, with a due-cycle scoreboard queue.
module tb_ahb_lite_slave_controller;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HSEL;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HRESP;
    logic        outputEnable;
    logic [63:0] outputData;
    logic        enable;
    logic        encryptionType;
    logic [63:0] data;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;

    ahb_lite_slave_controller #(.BASE_ADDR(32'h0000_0000)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
        .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS), .HBURST(HBURST),
        .HSIZE(HSIZE), .HPROT(HPROT), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HRESP(HRESP), .outputEnable(outputEnable),
        .outputData(outputData), .enable(enable), .encryptionType(encryptionType),
        .data(data), .key1(key1), .key2(key2), .key3(key3)
    );

    always #5 HCLK = ~HCLK;

    // kind: -1 none, 0 HRDATA, 1 data, 2 key1, 3 key2, 4 key3, 5 encryptionType
    typedef struct {
        bit          sel;
        bit          rdy;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          kind;
        logic [63:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        int          due;
        int          kind;
        logic [63:0] exp;
        string       name;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbq[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    logic [63:0] pend_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("check %-12s ok   act=%h", name, act);
        end else begin
            $display("FAIL %-12s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] probe(input int kind);
        case (kind)
            0:       return HRDATA;
            1:       return data;
            2:       return key1;
            3:       return key2;
            4:       return key3;
            5:       return {63'b0, encryptionType};
            default: return 64'hx;
        endcase
    endfunction

    // One bus cycle: drive this address phase and the previous transfer's write data,
    // then compare everything scheduled for this cycle at the falling edge.
    task automatic step(input bit sel, input bit rdy, input logic [1:0] trans, input bit wr,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input int kind, input logic [63:0] exp, input string name);
        sb_t e;
        HSEL   = sel;
        HREADY = rdy;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HWDATA = pend_wdata;
        pend_wdata = wdata;
        if (kind >= 0) begin
            e.due  = (kind == 0) ? cyc + 1 : cyc + 2;
            e.kind = kind;
            e.exp  = exp;
            e.name = name;
            sbq.push_back(e);
        end
        @(negedge HCLK);
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            check(e.name, probe(e.kind), e.exp);
        end
        check("hresp", {63'b0, HRESP}, 64'h0);
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 64'h0, -1, 64'h0, "");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [63:0] exp, input string name);
        step(1'b1, 1'b1, 2'b10, 1'b0, addr, 64'h0, 0, exp, name);
    endtask

    task automatic wrt(input logic [31:0] addr, input logic [63:0] wdata);
        step(1'b1, 1'b1, 2'b10, 1'b1, addr, wdata, -1, 64'h0, "");
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && sbq.size() > 0; i++)
            idle();
        if (sbq.size() != 0) begin
            check("sb_drain", 64'(sbq.size()), 64'h0);
            sbq.delete();
        end
    endtask

    initial begin
        HRESET = 1'b1; HMASTLOCK = 1'b0; HREADY = 1'b1; HSEL = 1'b0; HWRITE = 1'b0;
        HTRANS = 2'b00; HBURST = 3'b000; HSIZE = 3'b011; HPROT = 4'b0011;
        HADDR = '0; HWDATA = '0; outputEnable = 1'b0; outputData = '0;

        vecs.push_back('{1, 1, 2'b10, 1, 32'h00, 64'h0123456789ABCDEF, 1, 64'h0123456789ABCDEF, "wr_data"});
        vecs.push_back('{1, 1, 2'b10, 1, 32'h08, 64'h133457799BBCDFF1, 2, 64'h133457799BBCDFF1, "wr_key1"});
        vecs.push_back('{1, 1, 2'b10, 1, 32'h10, 64'h1122334455667788, 3, 64'h1122334455667788, "wr_key2"});
        vecs.push_back('{1, 1, 2'b11, 1, 32'h18, 64'hAABBCCDDEEFF0011, 4, 64'hAABBCCDDEEFF0011, "wr_key3"});
        vecs.push_back('{1, 1, 2'b10, 0, 32'h00, 64'h0, 0, 64'h0123456789ABCDEF, "rd_data"});
        vecs.push_back('{1, 1, 2'b11, 0, 32'h08, 64'h0, 0, 64'h133457799BBCDFF1, "rd_key1"});
        vecs.push_back('{1, 1, 2'b11, 0, 32'h10, 64'h0, 0, 64'h1122334455667788, "rd_key2"});
        vecs.push_back('{1, 1, 2'b11, 0, 32'h18, 64'h0, 0, 64'hAABBCCDDEEFF0011, "rd_key3"});
        vecs.push_back('{1, 1, 2'b10, 0, 32'h20, 64'h0, 0, 64'h0, "rd_ctrl0"});
        vecs.push_back('{1, 1, 2'b10, 0, 32'h28, 64'h0, 0, 64'h0, "rd_result0"});
        vecs.push_back('{1, 1, 2'b00, 1, 32'h00, 64'hFFFF, 1, 64'h0123456789ABCDEF, "wr_idle"});
        vecs.push_back('{1, 1, 2'b01, 1, 32'h00, 64'hFFFF, 1, 64'h0123456789ABCDEF, "wr_busy"});
        vecs.push_back('{0, 1, 2'b10, 1, 32'h00, 64'hFFFF, 1, 64'h0123456789ABCDEF, "wr_nosel"});
        vecs.push_back('{1, 0, 2'b10, 1, 32'h00, 64'hFFFF, 1, 64'h0123456789ABCDEF, "wr_noready"});
        vecs.push_back('{1, 1, 2'b10, 1, 32'h40, 64'hFFFF, 1, 64'h0123456789ABCDEF, "wr_unmap"});
        vecs.push_back('{1, 1, 2'b10, 1, 32'h100, 64'hFFFF, 1, 64'h0123456789ABCDEF, "wr_base"});
        vecs.push_back('{1, 1, 2'b10, 0, 32'h40, 64'h0, 0, 64'h0, "rd_unmap"});
        vecs.push_back('{1, 1, 2'b10, 0, 32'h108, 64'h0, 0, 64'h0, "rd_base"});
        vecs.push_back('{1, 1, 2'b10, 0, 32'h00, 64'h0, 0, 64'h0123456789ABCDEF, "rd_data2"});

        // Reset for two cycles
        idle();
        idle();
        HRESET = 1'b0;
        check("rst_data", data, 64'h0);
        check("rst_key1", key1, 64'h0);
        check("rst_key2", key2, 64'h0);
        check("rst_key3", key3, 64'h0);
        check("rst_enc", {63'b0, encryptionType}, 64'h0);
        check("rst_enable", {63'b0, enable}, 64'h0);
        check("rst_hrdata", HRDATA, 64'h0);
        check("rst_hresp", {63'b0, HRESP}, 64'h0);

        foreach (vecs[i])
            step(vecs[i].sel, vecs[i].rdy, vecs[i].trans, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, vecs[i].kind, vecs[i].exp, vecs[i].name);
        drain();

        // CTRL write: start pulse lasts exactly one cycle after the data phase
        wrt(32'h20, 64'h1);
        check("en_dphase", {63'b0, enable}, 64'h0);
        idle();
        check("en_pulse", {63'b0, enable}, 64'h1);
        check("enc_type", {63'b0, encryptionType}, 64'h1);
        idle();
        check("en_clear", {63'b0, enable}, 64'h0);

        // Cipher result capture and status
        outputEnable = 1'b1;
        outputData   = 64'h85E813540F0AB405;
        idle();
        outputEnable = 1'b0;
        outputData   = 64'h0;
        rd(32'h28, 64'h85E813540F0AB405, "rd_result");
        rd(32'h30, 64'h1, "rd_status1");
        rd(32'h20, 64'h1, "rd_ctrl1");
        wrt(32'h20, 64'h0);
        rd(32'h30, 64'h0, "rd_status_c");
        drain();
        check("enc_type0", {63'b0, encryptionType}, 64'h0);

        // Result arriving in the same cycle as a CTRL write: valid stays clear
        outputEnable = 1'b1;
        outputData   = 64'h1111;
        idle();
        outputEnable = 1'b0;
        wrt(32'h20, 64'h1);
        outputEnable = 1'b1;
        outputData   = 64'hDEADBEEFCAFEF00D;
        rd(32'h30, 64'h0, "rd_status_cl");
        outputEnable = 1'b0;
        rd(32'h28, 64'hDEADBEEFCAFEF00D, "rd_result2");
        wrt(32'h28, 64'h5);
        wrt(32'h30, 64'h1);
        rd(32'h28, 64'hDEADBEEFCAFEF00D, "rd_result_ro");
        rd(32'h30, 64'h0, "rd_status_ro");
        drain();

        // Reset during a pending write data phase drops the write
        wrt(32'h00, 64'h5555555555555555);
        HRESET = 1'b1;
        idle();
        HRESET = 1'b0;
        check("rrst_data", data, 64'h0);
        check("rrst_enc", {63'b0, encryptionType}, 64'h0);
        check("rrst_hrdata", HRDATA, 64'h0);
        rd(32'h00, 64'h0, "rrst_rd_data");
        rd(32'h08, 64'h0, "rrst_rd_key1");
        rd(32'h18, 64'h0, "rrst_rd_key3");
        rd(32'h28, 64'h0, "rrst_rd_res");
        rd(32'h30, 64'h0, "rrst_rd_stat");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_lite_slave_controller.md
Name: ahb_lite_slave_controller

Overview:
- AHB-Lite zero-wait-state slave that fronts the Triple-DES core.
- The bus master writes a 64-bit data block, three 64-bit keys and a control word through memory-mapped registers.
- The block drives the cipher inputs, issues a one-cycle start pulse, captures the cipher result and returns it on reads.

Parameters:
- BASE_ADDR, 32'h0000_0000, slave base address. HADDR[31:8] must equal BASE_ADDR[31:8] for a register hit.

Ports:
- HCLK  in  1  system clock; all state changes on its rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HMASTLOCK  in  1  locked-transfer indicator; ignored.
- HREADY  in  1  bus ready; an address phase is accepted only when it is high.
- HSEL  in  1  slave select.
- HWRITE  in  1  1 = write, 0 = read.
- HTRANS  in  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HBURST  in  3  burst type; ignored.
- HSIZE  in  3  transfer size; ignored, every access is a full 64 bits.
- HPROT  in  4  protection; ignored.
- HADDR  in  32  byte address.
- HWDATA  in  64  write data, sampled in the data phase.
- HRDATA  out  64  read data, valid in the data phase.
- HRESP  out  1  response; tied 0 (OKAY).
- outputEnable  in  1  cipher result valid strobe.
- outputData  in  64  cipher result.
- enable  out  1  one-cycle start pulse to the cipher.
- encryptionType  out  1  1 = encrypt, 0 = decrypt.
- data  out  64  plaintext/ciphertext register.
- key1, key2, key3  out  64 each  key registers.

Behaviour:
- Register map, offset is HADDR[7:0]:
  - 0x00 DATA (RW)
  - 0x08 KEY1 (RW)
  - 0x10 KEY2 (RW)
  - 0x18 KEY3 (RW)
  - 0x20 CTRL (RW, bit0 = encryptionType, other bits read 0)
  - 0x28 RESULT (RO)
  - 0x30 STATUS (RO, bit0 = result valid)
  - Any other offset, or a BASE_ADDR mismatch, is unmapped.
- Address phase accepted when HSEL & HREADY & HTRANS[1] are all 1. On acceptance, register the offset, the write flag and a valid flag.
  - IDLE or BUSY transfers, HSEL=0, or HREADY=0 leave the valid flag clear, so the next cycle has no data phase.
- Data phase is the cycle after acceptance.
  - Write: the register at the latched offset takes HWDATA at the end of the cycle.
  - Read: HRDATA combinationally shows the latched register. It shows 64'h0 when there is no data phase or the offset is unmapped.
- Unmapped writes are ignored; unmapped reads return 0. HRESP is always 0. The slave never inserts wait states.
- Back-to-back pipelined transfers are supported: a data phase and the next address phase may occur in the same cycle.
- Write to CTRL:
  - encryptionType = HWDATA[0].
  - enable = 1 for exactly the next cycle, registered.
  - STATUS.valid is cleared.
- When outputEnable=1: RESULT <= outputData and STATUS.valid <= 1.
  - If a CTRL write lands in the same cycle, the CTRL clear wins (valid = 0); RESULT is still updated.
- Outputs data, key1, key2, key3 and encryptionType are direct register outputs.
- Writes to RESULT or STATUS are ignored.
- Reset (HRESET=1 at a clock edge):
  - All registers go to 0, including RESULT and STATUS.
  - enable=0, HRDATA=0, the pending data-phase valid flag is cleared, HRESP=0.
  - A transfer in flight during reset is dropped.

Decomposition:
- Package ahb_tdes_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - Register offset constants (DATA, KEY1, KEY2, KEY3, CTRL, RESULT, STATUS).
  - HRESP_OKAY.
- No sub-module: address-phase pipeline register plus register file in one module.

Test Plan:
- Assert HRESET for 2 cycles -> data, key1, key2, key3, encryptionType and enable are all 0; HRDATA=0; HRESP=0.
- NONSEQ writes with HSEL=1, HREADY=1: 64'h0123456789ABCDEF to 0x00, 64'h133457799BBCDFF1 to 0x08, 64'h1122334455667788 to 0x10, 64'hAABBCCDDEEFF0011 to 0x18 -> each output updates at the end of its data phase. Read-back of each address returns the written value with zero wait states.
- Write 64'h1 to 0x20 -> encryptionType=1. enable is high for exactly one cycle, then 0.
- Drive outputEnable=1 with outputData=64'h85E813540F0AB405 for one cycle -> read 0x28 returns that value; read 0x30 returns 64'h1. A later CTRL write returns 0x30 to 0.
- HTRANS=IDLE with HSEL=1, or HSEL=0 with HTRANS=NONSEQ, writing 64'hFFFF to 0x00 -> DATA unchanged. Write to 0x40 -> ignored. Read of 0x40 returns 0 and HRESP stays 0.
- Raise HRESET during a pending write data phase -> the write is discarded and all registers read 0 afterward.
